// File: rtl/abr_addsub_ctrl_pkg.sv
// Shared state encoding and error-bit positions for the modular add/sub issue controller.
package abr_addsub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } addsub_ctrl_state_e;

  localparam int ERR_TIMEOUT_BIT = 0;
  localparam int ERR_RANGE_BIT   = 1;

endpackage

// File: rtl/abr_addsub_res_fifo.sv
// Result buffer for the add/sub issue controller: sync FIFO, registered count, 0-cycle head view.
// Caller guarantees no push when full and no pop when empty; clr_i empties it synchronously.
module abr_addsub_res_fifo #(
  parameter int WIDTH = 385,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic [$clog2(DEPTH):0]     cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Power-of-two depth lets the pointers wrap on natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
    else if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign cnt_o      = cnt_q;

endmodule

// File: rtl/abr_addsub_issue_ctrl.sv
// Issue stage for the 2-cycle modular add/sub unit: one op in flight, results returned in order through a FIFO.
// Accept to out_valid_o is 4 cycles; define ABR_ADDSUB_CTRL_OPCHK_EN to reject operands >= prime_i.
module abr_addsub_issue_ctrl
  import abr_addsub_ctrl_pkg::*;
#(
  parameter int REG_SIZE   = 384,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                zeroize,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                in_sub_i,
  input  logic [REG_SIZE-1:0] in_opa_i,
  input  logic [REG_SIZE-1:0] in_opb_i,
  input  logic                in_last_i,
  input  logic [REG_SIZE-1:0] prime_i,
  output logic                au_add_en_o,
  output logic                au_sub_o,
  output logic [REG_SIZE-1:0] au_opa_o,
  output logic [REG_SIZE-1:0] au_opb_o,
  output logic [REG_SIZE-1:0] au_prime_o,
  input  logic [REG_SIZE-1:0] au_res_i,
  input  logic                au_ready_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [REG_SIZE-1:0] out_res_o,
  output logic                out_last_o,
  output logic                busy_o,
  output logic [1:0]          err_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  addsub_ctrl_state_e  state_q, state_d;
  logic                sub_q, sub_d;
  logic                last_q, last_d;
  logic [REG_SIZE-1:0] opa_q, opa_d;
  logic [REG_SIZE-1:0] opb_q, opb_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [1:0]          err_q, err_d;

  logic                accept, range_err, tmo_hit, push, pop;
  logic [CNT_W-1:0]    fifo_cnt;
  logic [REG_SIZE:0]   fifo_head;

`ifdef ABR_ADDSUB_CTRL_OPCHK_EN
  assign range_err = (in_opa_i >= prime_i) || (in_opb_i >= prime_i);
`else
  assign range_err = 1'b0;
`endif

  assign accept  = in_valid_i && in_ready_o;
  // Result wins over timeout when both land in the same WAIT cycle.
  assign tmo_hit = (state_q == WAIT) && !au_ready_i && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign push    = (state_q == WAIT) && au_ready_i;
  assign pop     = out_valid_o && out_ready_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else if (zeroize) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && !range_err) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (au_ready_i || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The FIFO slot is reserved here: accept only happens in IDLE with room left.
  always_comb begin
    in_ready_o  = (state_q == IDLE) && (fifo_cnt < CNT_W'(FIFO_DEPTH));
    au_add_en_o = (state_q == ISSUE);
    out_valid_o = (fifo_cnt != '0);
    busy_o      = (state_q != IDLE) || (fifo_cnt != '0);
  end

  always_comb begin
    sub_d  = sub_q;
    last_d = last_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    if (accept) begin
      sub_d  = in_sub_i;
      last_d = in_last_i;
      opa_d  = in_opa_i;
      opb_d  = in_opb_i;
    end
    tmo_d = tmo_q;
    if (state_q == ISSUE)     tmo_d = '0;
    else if (state_q == WAIT) tmo_d = tmo_q + TMO_W'(1);
    err_d = err_q;
    if (tmo_hit)               err_d[ERR_TIMEOUT_BIT] = 1'b1;
    if (accept && range_err)   err_d[ERR_RANGE_BIT]   = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub_q  <= 1'b0;
      last_q <= 1'b0;
      opa_q  <= '0;
      opb_q  <= '0;
      tmo_q  <= '0;
      err_q  <= '0;
    end else if (zeroize) begin
      sub_q  <= 1'b0;
      last_q <= 1'b0;
      opa_q  <= '0;
      opb_q  <= '0;
      tmo_q  <= '0;
      err_q  <= '0;
    end else begin
      sub_q  <= sub_d;
      last_q <= last_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      tmo_q  <= tmo_d;
      err_q  <= err_d;
    end
  end

  abr_addsub_res_fifo #(
    .WIDTH (REG_SIZE + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (zeroize),
    .push_i     (push),
    .push_dat_i ({au_res_i, last_q}),
    .pop_i      (pop),
    .head_dat_o (fifo_head),
    .cnt_o      (fifo_cnt)
  );

  assign au_sub_o   = sub_q;
  assign au_opa_o   = opa_q;
  assign au_opb_o   = opb_q;
  assign au_prime_o = prime_i;
  // Storage is not reset, so the head is masked until it holds a real entry.
  assign out_res_o  = out_valid_o ? fifo_head[REG_SIZE:1] : '0;
  assign out_last_o = out_valid_o ? fifo_head[0] : 1'b0;
  assign err_o      = err_q;

endmodule

// File: tb/tb_abr_addsub_issue_ctrl.sv
// Bench for abr_addsub_issue_ctrl with a 2-cycle add/sub unit model and an in-order result scoreboard.
module tb_abr_addsub_issue_ctrl;

  localparam int          W = 24;
  localparam logic [24:0] P = 25'd8380417;

  logic         clk = 1'b0;
  logic         reset_n, zeroize;
  logic         in_valid_i, in_ready_o, in_sub_i, in_last_i;
  logic [W-1:0] in_opa_i, in_opb_i, prime_i;
  logic         au_add_en_o, au_sub_o, au_ready_i;
  logic [W-1:0] au_opa_o, au_opb_o, au_prime_o, au_res_i;
  logic         out_valid_o, out_ready_i, out_last_o, busy_o;
  logic [W-1:0] out_res_o;
  logic [1:0]   err_o;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  logic [W:0] sb_q[$];
  logic model_hang = 1'b0;
  logic p1;

  always #5 clk = ~clk;

  abr_addsub_issue_ctrl #(.REG_SIZE(W), .FIFO_DEPTH(4), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_sub_i(in_sub_i),
    .in_opa_i(in_opa_i), .in_opb_i(in_opb_i), .in_last_i(in_last_i), .prime_i(prime_i),
    .au_add_en_o(au_add_en_o), .au_sub_o(au_sub_o), .au_opa_o(au_opa_o), .au_opb_o(au_opb_o),
    .au_prime_o(au_prime_o), .au_res_i(au_res_i), .au_ready_i(au_ready_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_res_o(out_res_o),
    .out_last_o(out_last_o), .busy_o(busy_o), .err_o(err_o)
  );

  function automatic logic [W-1:0] mod_as(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [24:0] s;
    if (sub) begin
      s = {1'b0, a} - {1'b0, b};
      if (a < b) s = s + P;
    end else begin
      s = {1'b0, a} + {1'b0, b};
      if (s >= P) s = s - P;
    end
    return s[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Unit model: enable sampled, result and ready two cycles later.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1 <= 1'b0; au_ready_i <= 1'b0; au_res_i <= '0;
    end else begin
      p1         <= au_add_en_o;
      au_ready_i <= p1 && !model_hang;
      if (au_add_en_o) au_res_i <= mod_as(au_sub_o, au_opa_o, au_opb_o);
    end
  end

  always @(negedge clk) if (au_add_en_o) en_cnt++;

  always @(negedge clk) begin
    if (reset_n && out_valid_o && out_ready_i) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out", {40'd0, out_res_o}, 64'hFFFF_FFFF);
      end else begin
        logic [W:0] e;
        e = sb_q.pop_front();
        chk("out_res", {40'd0, out_res_o}, {40'd0, e[W:1]});
        chk("out_last", {63'd0, out_last_o}, {63'd0, e[0]});
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic last, input logic exp_out, input logic [W-1:0] exp_res,
                         input int max_wait);
    logic acc;
    acc = 1'b0;
    in_valid_i = 1'b1; in_sub_i = sub; in_opa_i = a; in_opb_i = b; in_last_i = last;
    for (int i = 0; i < max_wait && !acc; i++) begin
      @(negedge clk);
      if (in_ready_o) begin
        acc = 1'b1;
        if (exp_out) sb_q.push_back({exp_res, last});
      end
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    chk("accept", {63'd0, acc}, 64'd1);
  endtask

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         last;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int snap;
    vecs[0] = '{1'b0, 24'd8380416, 24'd2,       1'b0, 24'd1};
    vecs[1] = '{1'b1, 24'd3,       24'd5,       1'b1, 24'd8380415};
    vecs[2] = '{1'b0, 24'd0,       24'd0,       1'b0, 24'd0};
    vecs[3] = '{1'b0, 24'd4190208, 24'd4190208, 1'b1, 24'd8380416};
    vecs[4] = '{1'b0, 24'd4190209, 24'd4190208, 1'b0, 24'd0};
    vecs[5] = '{1'b1, 24'd100,     24'd100,     1'b0, 24'd0};
    vecs[6] = '{1'b1, 24'd0,       24'd8380416, 1'b1, 24'd1};
    vecs[7] = '{1'b1, 24'd8380416, 24'd1,       1'b0, 24'd8380415};
    vecs[8] = '{1'b0, 24'd123456,  24'd654321,  1'b0, 24'd777777};
    vecs[9] = '{1'b0, 24'd8380416, 24'd8380416, 1'b1, 24'd8380415};

    reset_n = 1'b0; zeroize = 1'b0; in_valid_i = 1'b0; in_sub_i = 1'b0; in_last_i = 1'b0;
    in_opa_i = '0; in_opb_i = '0; prime_i = P[W-1:0]; out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_err", {62'd0, err_o}, 64'd0);
    chk("rst_en", {63'd0, au_add_en_o}, 64'd0);
    chk("rst_out_res", {40'd0, out_res_o}, 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Single ops: exact latency and one enable pulse each.
    for (int v = 0; v < 10; v++) begin
      snap = en_cnt;
      send_op(vecs[v].sub, vecs[v].a, vecs[v].b, vecs[v].last, 1'b1, vecs[v].exp, 20);
      @(negedge clk);
      chk("en_t1", {63'd0, au_add_en_o}, 64'd1);
      @(negedge clk);
      chk("en_t2", {63'd0, au_add_en_o}, 64'd0);
      @(negedge clk);
      chk("valid_t3", {63'd0, out_valid_o}, 64'd0);
      @(negedge clk);
      chk("valid_t4", {63'd0, out_valid_o}, 64'd1);
      chk("en_pulses", en_cnt - snap, 64'd1);
      @(posedge clk); #1;
    end

    // Backpressure: four fill the buffer, the fifth waits for a pop.
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      send_op(1'b0, W'(i * 1000 + 7), 24'd10, i[0], 1'b1, mod_as(1'b0, W'(i * 1000 + 7), 24'd10), 20);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    snap = en_cnt;
    in_valid_i = 1'b1; in_sub_i = 1'b0; in_opa_i = 24'd4007; in_opb_i = 24'd10; in_last_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_in_ready", {63'd0, in_ready_o}, 64'd0);
    end
    chk("full_busy", {63'd0, busy_o}, 64'd1);
    chk("full_no_issue", en_cnt - snap, 64'd0);
    @(posedge clk); #1 out_ready_i = 1'b1;
    @(negedge clk);
    chk("full_pop_cycle_ready", {63'd0, in_ready_o}, 64'd0);
    @(posedge clk); #1;
    send_op(1'b0, 24'd4007, 24'd10, 1'b0, 1'b1, mod_as(1'b0, 24'd4007, 24'd10), 1);
    send_op(1'b1, 24'd5, 24'd9, 1'b1, 1'b1, mod_as(1'b1, 24'd5, 24'd9), 20);
    for (int i = 0; i < 40 && (sb_q.size() != 0 || busy_o); i++) @(negedge clk);
    chk("bp_drained", sb_q.size(), 64'd0);
    @(posedge clk); #1;

    // Unit never answers: timeout after four WAIT cycles.
    model_hang = 1'b1;
    snap = en_cnt;
    send_op(1'b0, 24'd1, 24'd2, 1'b0, 1'b0, 24'd0, 20);
    repeat (5) @(negedge clk);
    chk("tmo_not_yet", {62'd0, err_o}, 64'd0);
    chk("tmo_busy", {63'd0, busy_o}, 64'd1);
    @(negedge clk);
    chk("tmo_err", {62'd0, err_o}, 64'd1);
    chk("tmo_idle", {63'd0, in_ready_o}, 64'd1);
    chk("tmo_not_busy", {63'd0, busy_o}, 64'd0);
    chk("tmo_one_issue", en_cnt - snap, 64'd1);
    repeat (3) @(negedge clk);
    chk("tmo_sticky", {62'd0, err_o}, 64'd1);
    chk("tmo_no_out", {63'd0, out_valid_o}, 64'd0);
    model_hang = 1'b0;
    @(posedge clk); #1;

    // Zeroize in WAIT with two results buffered.
    out_ready_i = 1'b0;
    send_op(1'b0, 24'd11, 24'd22, 1'b0, 1'b0, 24'd0, 20);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    send_op(1'b0, 24'd33, 24'd44, 1'b1, 1'b0, 24'd0, 20);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    send_op(1'b1, 24'd55, 24'd66, 1'b0, 1'b0, 24'd0, 20);
    @(negedge clk);
    chk("zz_buffered", {63'd0, out_valid_o}, 64'd1);
    @(posedge clk); #1 zeroize = 1'b1;
    @(posedge clk); #1 zeroize = 1'b0;
    @(negedge clk);
    chk("zz_out_valid", {63'd0, out_valid_o}, 64'd0);
    chk("zz_busy", {63'd0, busy_o}, 64'd0);
    chk("zz_in_ready", {63'd0, in_ready_o}, 64'd1);
    chk("zz_err", {62'd0, err_o}, 64'd0);
    @(posedge clk); #1 out_ready_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("zz_late_ready_ignored", {63'd0, out_valid_o}, 64'd0);
    chk("zz_still_idle", {63'd0, busy_o}, 64'd0);
    @(posedge clk); #1;

    // Operand at the modulus.
    snap = en_cnt;
`ifdef ABR_ADDSUB_CTRL_OPCHK_EN
    send_op(1'b0, 24'd8380417, 24'd1, 1'b0, 1'b0, 24'd0, 20);
    repeat (4) @(negedge clk);
    chk("opchk_err", {62'd0, err_o}, 64'd2);
    chk("opchk_no_issue", en_cnt - snap, 64'd0);
    chk("opchk_idle", {63'd0, busy_o}, 64'd0);
`else
    send_op(1'b0, 24'd8380417, 24'd1, 1'b0, 1'b1, mod_as(1'b0, 24'd8380417, 24'd1), 20);
    repeat (4) @(negedge clk);
    chk("opchk_err", {62'd0, err_o}, 64'd0);
    chk("opchk_issued", en_cnt - snap, 64'd1);
`endif
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    chk("final_drained", sb_q.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
